// File: rtl/sfifo_rd_skid_pkg.sv
// Shared types for the show-ahead FIFO read-side skid stage.
// The state encoding equals the number of buffered words.
package sfifo_rd_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/sfifo_rd_skid_cnt.sv
// Wrapping event counter with a 0..3 increment per clock.
// Used for both the delivered-word and the flushed-word tallies.
module sfifo_rd_skid_cnt #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    output logic [NBITS-1:0] cnt
);

    logic [NBITS-1:0] cnt_q;
    logic [NBITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + NBITS'(inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sfifo_rd_skid.sv
// Drains a show-ahead FIFO into a registered valid/ready stream through a
// main + skid register pair, keeping fifo_rd independent of dout_ready.
module sfifo_rd_skid
    import sfifo_rd_skid_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int CNT_NBITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 fifo_rd,
    output logic                 dout_valid,
    output logic [WIDTH-1:0]     dout,
    input  logic                 dout_ready,
    input  logic                 flush,
    output logic [1:0]           level,
    output logic [CNT_NBITS-1:0] xfer_cnt,
    output logic [CNT_NBITS-1:0] drop_cnt
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] main_data_d;
    logic [WIDTH-1:0] skid_data_q;
    logic [WIDTH-1:0] skid_data_d;

    logic             main_v;
    logic             skid_v;
    logic             xfer;
    logic [1:0]       xfer_inc;
    logic [1:0]       drop_inc;

    assign main_v     = (state_q != ST_EMPTY);
    assign skid_v     = (state_q == ST_TWO);
    assign xfer       = main_v & dout_ready;
    assign level      = state_q;
    assign dout_valid = main_v;
    assign dout       = main_data_q;

    // The pop decision only looks at registered occupancy, never at dout_ready.
    assign fifo_rd    = ~fifo_empty & ~skid_v & ~flush & ~rst;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (fifo_rd) begin
                        state_d     = ST_ONE;
                        main_data_d = fifo_dout;
                    end
                end
                ST_ONE: begin
                    if (fifo_rd && xfer) begin
                        main_data_d = fifo_dout;
                    end else if (fifo_rd) begin
                        state_d     = ST_TWO;
                        skid_data_d = fifo_dout;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (xfer) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // A handshake during flush still counts as delivered, not dropped.
    assign xfer_inc = {1'b0, xfer};
    assign drop_inc = flush ? (level - {1'b0, xfer}) : 2'd0;

    sfifo_rd_skid_cnt #(
        .NBITS (CNT_NBITS)
    ) u_xfer_cnt (
        .clk (clk),
        .rst (rst),
        .inc (xfer_inc),
        .cnt (xfer_cnt)
    );

    sfifo_rd_skid_cnt #(
        .NBITS (CNT_NBITS)
    ) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );

endmodule

// File: tb/tb_sfifo_rd_skid.sv
// Self-checking bench: queue-based FIFO and buffer model, table vectors,
// directed corner sequences and a randomized stream.
module tb_sfifo_rd_skid;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [11:0] fifo_dout;
    logic        dout_ready;
    logic        flush;

    logic        fifo_rd,    fifo_rd4;
    logic        dout_valid, dout_valid4;
    logic [11:0] dout,       dout4;
    logic [1:0]  level,      level4;
    logic [15:0] xfer_cnt,   drop_cnt;
    logic [3:0]  xfer_cnt4,  drop_cnt4;

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 0;
    bit          rd_seen;

    logic [11:0] fq[$];
    logic [11:0] mq[$];
    logic [15:0] m_x;
    logic [15:0] m_d;

    typedef struct {
        bit          ready;
        bit          exp_rd;
        bit          exp_valid;
        logic [11:0] exp_dout;
        int          exp_level;
        int          exp_xcnt;
    } vec_t;

    vec_t vecs[8];

    sfifo_rd_skid dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ready (dout_ready),
        .flush      (flush),
        .level      (level),
        .xfer_cnt   (xfer_cnt),
        .drop_cnt   (drop_cnt)
    );

    sfifo_rd_skid #(
        .WIDTH     (12),
        .CNT_NBITS (4)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd4),
        .dout_valid (dout_valid4),
        .dout       (dout4),
        .dout_ready (dout_ready),
        .flush      (flush),
        .level      (level4),
        .xfer_cnt   (xfer_cnt4),
        .drop_cnt   (drop_cnt4)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushWord(input logic [11:0] w);
        fq.push_back(w);
    endtask

    // Drive inputs at the falling edge and let combinational outputs settle.
    task automatic applyStimulus(input bit r_rst, input bit r_flush, input bit r_ready);
        rst        = r_rst;
        flush      = r_flush;
        dout_ready = r_ready;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? 12'($urandom) : fq[0];
        #1;
        rd_seen = fifo_rd;
    endtask

    // Compare both DUTs with the model; then advance the model and clock.
    task automatic checkOutput();
        bit exp_rd;
        bit xf;
        exp_rd = (fq.size() != 0) && (mq.size() < 2) && !flush && !rst;
        if (chk_en) begin
            checkVal("fifo_rd", fifo_rd, exp_rd);
            checkVal("fifo_rd4", fifo_rd4, exp_rd);
            checkVal("dout_valid", dout_valid, mq.size() > 0);
            checkVal("dout_valid4", dout_valid4, mq.size() > 0);
            checkVal("level", level, mq.size());
            checkVal("level4", level4, mq.size());
            checkVal("xfer_cnt", xfer_cnt, m_x);
            checkVal("drop_cnt", drop_cnt, m_d);
            checkVal("xfer_cnt4", xfer_cnt4, m_x[3:0]);
            checkVal("drop_cnt4", drop_cnt4, m_d[3:0]);
            if (mq.size() > 0) begin
                checkVal("dout", dout, mq[0]);
                checkVal("dout4", dout4, mq[0]);
            end
        end
        xf = (mq.size() > 0) && dout_ready;
        if (rst) begin
            mq.delete();
            m_x = 0;
            m_d = 0;
        end else if (flush) begin
            m_x = m_x + 16'(xf);
            m_d = m_d + 16'(mq.size()) - 16'(xf);
            mq.delete();
        end else begin
            if (xf) begin
                void'(mq.pop_front());
                m_x = m_x + 16'd1;
            end
            if (exp_rd) mq.push_back(fq[0]);
        end
        @(posedge clk);
        if (rd_seen && fq.size() > 0) void'(fq.pop_front());
        @(negedge clk);
    endtask

    task automatic doCycle(input bit r_rst, input bit r_flush, input bit r_ready);
        applyStimulus(r_rst, r_flush, r_ready);
        checkOutput();
    endtask

    task automatic drainAll();
        int n = 0;
        while ((mq.size() > 0 || fq.size() > 0) && n < 200) begin
            doCycle(0, 0, 1);
            n++;
        end
        checkVal("drain_done", (mq.size() == 0 && fq.size() == 0), 1);
    endtask

    initial begin
        logic [15:0] x0, d0, xs;
        int pushed, cyc;

        rst = 1; flush = 0; dout_ready = 0; fifo_empty = 1; fifo_dout = 0;
        m_x = 0; m_d = 0;
        doCycle(1, 0, 0);
        doCycle(1, 0, 0);
        chk_en = 1;

        // Reset state
        applyStimulus(0, 0, 0);
        checkVal("rst_valid", dout_valid, 0);
        checkVal("rst_level", level, 0);
        checkVal("rst_xcnt", xfer_cnt, 0);
        checkVal("rst_dcnt", drop_cnt, 0);
        checkOutput();

        // Stall then release: 3 queued words
        vecs[0] = '{0, 1, 0, 12'h000, 0, 0};
        vecs[1] = '{0, 1, 1, 12'h001, 1, 0};
        vecs[2] = '{0, 0, 1, 12'h001, 2, 0};
        vecs[3] = '{0, 0, 1, 12'h001, 2, 0};
        vecs[4] = '{1, 0, 1, 12'h001, 2, 0};
        vecs[5] = '{1, 1, 1, 12'h002, 1, 1};
        vecs[6] = '{1, 0, 1, 12'h003, 1, 2};
        vecs[7] = '{1, 0, 0, 12'h000, 0, 3};
        pushWord(12'h001); pushWord(12'h002); pushWord(12'h003);
        foreach (vecs[i]) begin
            applyStimulus(0, 0, vecs[i].ready);
            checkVal($sformatf("vec%0d_rd", i), fifo_rd, vecs[i].exp_rd);
            checkVal($sformatf("vec%0d_valid", i), dout_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) checkVal($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            checkVal($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
            checkVal($sformatf("vec%0d_xcnt", i), xfer_cnt, vecs[i].exp_xcnt);
            checkOutput();
        end

        // Full-rate stream of 0x001..0x010
        for (int w = 1; w <= 16; w++) pushWord(12'(w));
        for (int i = 0; i < 18; i++) begin
            applyStimulus(0, 0, 1);
            checkVal($sformatf("stream%0d_rd", i), fifo_rd, (i < 16));
            checkVal($sformatf("stream%0d_valid", i), dout_valid, (i >= 1 && i <= 16));
            if (i >= 1 && i <= 16) checkVal($sformatf("stream%0d_dout", i), dout, i);
            checkOutput();
        end
        checkVal("stream_xcnt", xfer_cnt, 19);
        checkVal("stream_level", level, 0);

        // Flush while holding two words with a handshake in the same cycle
        x0 = m_x; d0 = m_d;
        for (int w = 0; w < 4; w++) pushWord(12'h0C0 + 12'(w));
        doCycle(0, 0, 0);
        doCycle(0, 0, 0);
        applyStimulus(0, 1, 1);
        checkVal("flush_rd", fifo_rd, 0);
        checkVal("flush_level", level, 2);
        checkOutput();
        applyStimulus(0, 0, 1);
        checkVal("post_flush_level", level, 0);
        checkVal("post_flush_valid", dout_valid, 0);
        checkVal("post_flush_xcnt", xfer_cnt, x0 + 16'd1);
        checkVal("post_flush_dcnt", drop_cnt, d0 + 16'd1);
        checkOutput();
        applyStimulus(0, 0, 1);
        checkVal("post_flush_head", dout, 12'h0C2);
        checkOutput();
        drainAll();

        // Synchronous reset with two words buffered
        for (int w = 0; w < 5; w++) pushWord(12'h0B0 + 12'(w));
        doCycle(0, 0, 0);
        doCycle(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkVal("pre_rst_level", level, 2);
        checkOutput();
        applyStimulus(1, 0, 0);
        checkVal("in_rst_rd", fifo_rd, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        checkVal("after_rst_valid", dout_valid, 0);
        checkVal("after_rst_level", level, 0);
        checkVal("after_rst_xcnt", xfer_cnt, 0);
        checkVal("after_rst_dcnt", drop_cnt, 0);
        checkOutput();
        applyStimulus(0, 0, 0);
        checkVal("after_rst_head", dout, 12'h0B2);
        checkOutput();
        drainAll();

        // Counter wrap: 17 transfers on the 4-bit instance
        doCycle(1, 0, 0);
        for (int w = 0; w < 17; w++) pushWord(12'h300 + 12'(w));
        drainAll();
        checkVal("wrap_xcnt4", xfer_cnt4, 1);
        checkVal("wrap_xcnt", xfer_cnt, 17);

        // Randomized refill and 50% ready over 1000 words
        xs = m_x; pushed = 0; cyc = 0;
        while (16'(m_x - xs) < 16'd1000 && cyc < 20000) begin
            if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)) && pushed < 1000; k++) begin
                    pushWord(12'($urandom));
                    pushed++;
                end
            end
            doCycle(0, 0, 1'($urandom_range(0, 1)));
            cyc++;
        end
        checkVal("rand_done", (16'(m_x - xs) == 16'd1000), 1);
        applyStimulus(0, 0, 0);
        checkVal("rand_xcnt", xfer_cnt, 16'(17 + 1000));
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
